// File: rtl/char_ram_arbiter.sv
// Character RAM arbiter for a 640x480 text display (COLS x ROWS cells of 8x16 pixels).
// Display fetches always win the single RAM port. Terminal writes use the remaining cycles.
// An optional clear-screen sweep is compiled in when CHAR_ARB_CLEAR_EN is defined. Without
// it, clr_req is ignored and clr_busy stays 0.
module char_ram_arbiter #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  xPos,
  input  logic [9:0]  yPos,
  input  logic        valid,
  input  logic        wr_req,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_code,
  output logic        char_valid
);

  localparam logic [11:0] CELLS     = 12'(COLS * ROWS);
  localparam logic [11:0] LAST_CELL = CELLS - 12'd1;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [11:0] r_addr_last;
  logic        r_fetch_d1;
  logic [7:0]  r_char_code;
  logic        r_char_valid;

  logic        w_fetch;
  logic [4:0]  w_row;
  logic [6:0]  w_col;
  logic [11:0] w_fetch_addr;
  logic        w_wr_in_range;
  logic        w_we;
  logic [11:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_ack;
  logic        w_busy;

`ifdef CHAR_ARB_CLEAR_EN
  logic [11:0] r_clr_cnt;
  logic [11:0] w_clr_cnt_next;
  logic        w_unused;
  assign w_unused = ^{yPos[9], yPos[3:0]};
`else
  logic        w_unused;
  assign w_unused = ^{clr_req, BLANK, yPos[9], yPos[3:0]};
`endif

  // A fetch happens on the first pixel of every visible 8-pixel character cell.
  assign w_fetch       = valid && (xPos[2:0] == 3'b000);
  assign w_row         = yPos[8:4];
  assign w_col         = xPos[9:3];
  // row*80 + col, written as shifts so no multiplier is needed.
  assign w_fetch_addr  = {1'b0, w_row, 6'b0} + {3'b0, w_row, 4'b0} + {5'b0, w_col};
  assign w_wr_in_range = (wr_addr < CELLS);

  // Next-state and RAM port arbitration: fetch first, then clear sweep or terminal write.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_addr       = r_addr_last;
    w_wdata      = 8'h00;
    w_ack        = 1'b0;
    w_busy       = 1'b0;
`ifdef CHAR_ARB_CLEAR_EN
    w_clr_cnt_next = r_clr_cnt;
`endif

    if (w_fetch) begin
      w_addr = w_fetch_addr;
    end

    unique case (r_state)
      StIdle: begin
`ifdef CHAR_ARB_CLEAR_EN
        // A clear request beats a pending write; the write waits for the sweep to finish.
        if (clr_req) begin
          w_state_next   = StClear;
          w_clr_cnt_next = 12'd0;
        end else
`endif
        if (!w_fetch && wr_req) begin
          // Out-of-range writes are acknowledged but dropped.
          w_ack   = 1'b1;
          w_we    = w_wr_in_range;
          w_addr  = wr_addr;
          w_wdata = wr_data;
        end
      end
`ifdef CHAR_ARB_CLEAR_EN
      StClear: begin
        w_busy = 1'b1;
        if (!w_fetch) begin
          w_we    = 1'b1;
          w_addr  = r_clr_cnt;
          w_wdata = BLANK;
          if (r_clr_cnt == LAST_CELL) begin
            w_state_next = StIdle;
          end else begin
            w_clr_cnt_next = r_clr_cnt + 12'd1;
          end
        end
      end
`endif
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // No writes and no acknowledges while reset is held.
    if (reset) begin
      w_we  = 1'b0;
      w_ack = 1'b0;
    end
  end

  assign ram_we     = w_we;
  assign ram_addr   = w_addr;
  assign ram_wdata  = w_wdata;
  assign wr_ack     = w_ack;
  assign clr_busy   = w_busy;
  assign char_code  = r_char_code;
  assign char_valid = r_char_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef CHAR_ARB_CLEAR_EN
  // Clear sweep address counter; reset aborts the sweep wherever it is.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt <= 12'd0;
    end else begin
      r_clr_cnt <= w_clr_cnt_next;
    end
  end
`endif

  // Remember the last driven address so idle cycles leave ram_addr unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_last <= 12'd0;
    end else begin
      r_addr_last <= w_addr;
    end
  end

  // Fetch pipeline: RAM data arrives in F+1 and is registered for presentation in F+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_d1   <= 1'b0;
      r_char_code  <= 8'h00;
      r_char_valid <= 1'b0;
    end else begin
      r_fetch_d1   <= w_fetch;
      r_char_valid <= r_fetch_d1;
      if (r_fetch_d1) begin
        r_char_code <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Self-checking bench for char_ram_arbiter. Expected characters are queued when a fetch is
// driven and compared (value and cycle) when char_valid pulses. Clear sweep coverage follows
// CHAR_ARB_CLEAR_EN.
module tb_char_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  xPos;
  logic [9:0]  yPos;
  logic        valid;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        clr_req;
  logic        clr_busy;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic        char_valid;

  always #5 clk = ~clk;

  char_ram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .xPos      (xPos),
    .yPos      (yPos),
    .valid     (valid),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .char_code (char_code),
    .char_valid(char_valid)
  );

  // Character RAM (one-cycle synchronous read) plus a bench-side preload port.
  bit   [7:0]  mem    [4096];
  bit   [7:0]  shadow [4096];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    int         due;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every char_valid pulse must match the oldest queued fetch, in value and cycle.
  always @(negedge clk) begin
    if (char_valid === 1'b1) begin
      if (q.size() == 0) begin
        check_eq("char_valid_unexpected", 32'd1, 32'd0);
      end else begin
        m_e = q.pop_front();
        check_eq("char_valid_cycle", cyc, m_e.due);
        check_eq("char_code", {24'd0, char_code}, {24'd0, m_e.code});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = 12'(a);
    pl_data = d;
    tick();
    pl_we     = 1'b0;
    shadow[a] = d;
  endtask

  task automatic fetch(input int x, input int y);
    int a;
    a     = (y / 16) * 80 + x / 8;
    valid = 1'b1;
    xPos  = 10'(x);
    yPos  = 10'(y);
    @(negedge clk);
    check_eq("fetch_addr", ram_addr, a);
    check_eq("fetch_we", ram_we, 0);
    q.push_back('{shadow[a], cyc + 2});
    tick();
    valid = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d);
    bit ok;
    ok      = (a < 12'd2400);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    check_eq("wr_ack", wr_ack, 1);
    check_eq("wr_we", ram_we, ok);
    check_eq("wr_addr", ram_addr, a);
    if (ok) check_eq("wr_wdata", ram_wdata, d);
    tick();
    wr_req = 1'b0;
    if (ok) shadow[a] = d;
    @(negedge clk);
    check_eq("idle_ack", wr_ack, 0);
    check_eq("idle_we", ram_we, 0);
    check_eq("idle_wdata", ram_wdata, 0);
    check_eq("idle_addr_hold", ram_addr, a);
    tick();
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] != shadow[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int wr_n;
    int ack_n;
    reset   = 1'b1;
    valid   = 1'b0;
    xPos    = '0;
    yPos    = '0;
    wr_req  = 1'b1;
    wr_addr = 12'd3;
    wr_data = 8'h99;
    clr_req = 1'b0;

    // Reset: a pending write is neither performed nor acknowledged.
    @(negedge clk);
    check_eq("rst_ack", wr_ack, 0);
    check_eq("rst_we", ram_we, 0);
    tick();
    tick();
    check_eq("rst_char_code", char_code, 0);
    check_eq("rst_char_valid", char_valid, 0);
    check_eq("rst_clr_busy", clr_busy, 0);
    wr_req = 1'b0;
    reset  = 1'b0;
    tick();

    // Basic fetch: row 2, col 2 -> cell 162.
    preload(162, 8'h41);
    fetch(16, 32);
    repeat (3) tick();

    // Assorted cells including the last one; back-to-back fetches.
    preload(0, 8'h10);
    preload(2399, 8'hA5);
    preload(81, 8'h3C);
    preload(1234, 8'(($urandom % 254) + 1));
    fetch(0, 0);
    fetch(632, 479);
    fetch(8, 16);
    fetch(272, 245);
    repeat (3) tick();

    // Visible but mid-cell pixel is not a fetch: port stays idle.
    valid = 1'b1;
    xPos  = 10'd13;
    yPos  = 10'd40;
    @(negedge clk);
    check_eq("nofetch_we", ram_we, 0);
    check_eq("nofetch_wdata", ram_wdata, 0);
    tick();
    valid = 1'b0;

    // Write held across a fetch cycle is serviced in the next free cycle.
    valid   = 1'b1;
    xPos    = 10'd0;
    yPos    = 10'd0;
    wr_req  = 1'b1;
    wr_addr = 12'd5;
    wr_data = 8'h42;
    @(negedge clk);
    check_eq("f_wr_ack", wr_ack, 0);
    check_eq("f_wr_we", ram_we, 0);
    q.push_back('{shadow[0], cyc + 2});
    tick();
    valid = 1'b0;
    @(negedge clk);
    check_eq("f1_wr_ack", wr_ack, 1);
    check_eq("f1_wr_we", ram_we, 1);
    check_eq("f1_wr_addr", ram_addr, 5);
    check_eq("f1_wr_data", ram_wdata, 8'h42);
    tick();
    wr_req    = 1'b0;
    shadow[5] = 8'h42;
    @(negedge clk);
    check_eq("f2_no_double_ack", wr_ack, 0);
    tick();
    fetch(40, 0);
    repeat (3) tick();

    // In-range writes and discarded out-of-range writes.
    do_write(12'd2399, 8'h5A);
    do_write(12'd2400, 8'hEE);
    do_write(12'd4095, 8'hEF);
    do_write(12'd77, 8'h61);
    fetch(632, 479);
    repeat (3) tick();
    check_mem("mem_after_writes");

`ifdef CHAR_ARB_CLEAR_EN
    // Full clear with a concurrent write; a second clr_req mid-sweep must not restart it.
    wr_req  = 1'b1;
    wr_addr = 12'd7;
    wr_data = 8'h55;
    clr_req = 1'b1;
    @(negedge clk);
    check_eq("clr_start_ack", wr_ack, 0);
    check_eq("clr_start_we", ram_we, 0);
    tick();
    clr_req = 1'b0;
    busy_n  = 0;
    wr_n    = 0;
    ack_n   = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (clr_busy !== 1'b1) break;
      busy_n++;
      if (ram_we === 1'b1) wr_n++;
      if (wr_ack === 1'b1) ack_n++;
      clr_req = (busy_n == 500);
      tick();
    end
    clr_req = 1'b0;
    check_eq("clr_busy_cycles", busy_n, 2400);
    check_eq("clr_write_cycles", wr_n, 2400);
    check_eq("clr_acks_while_busy", ack_n, 0);
    check_eq("post_clr_ack", wr_ack, 1);
    check_eq("post_clr_addr", ram_addr, 7);
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 2400; i++) shadow[i] = 8'h20;
    shadow[7] = 8'h55;
    tick();
    check_mem("mem_after_clear");
    fetch(632, 479);
    fetch(56, 0);
    repeat (3) tick();

    // Reset while the sweep is at cell 100.
    preload(100, 8'h77);
    preload(50, 8'h11);
    preload(0, 8'h12);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    @(negedge clk);
    check_eq("clr_rst_we", ram_we, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("clr_rst_busy", clr_busy, 0);
    for (int i = 0; i < 100; i++) shadow[i] = 8'h20;
    tick();
    check_mem("mem_after_clear_abort");
    check_eq("cell100_kept", mem[100], 8'h77);
`else
    // Clear requests have no effect in this build.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_n    = 0;
    busy_n  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (clr_busy !== 1'b0) busy_n++;
      if (ram_we !== 1'b0) wr_n++;
      tick();
    end
    check_eq("noclr_busy", busy_n, 0);
    check_eq("noclr_writes", wr_n, 0);
    check_mem("mem_after_noclr");
    ack_n = 0;
`endif

    // Fetch in flight when reset hits must not produce a pulse afterwards.
    valid = 1'b1;
    xPos  = 10'd8;
    yPos  = 10'd0;
    tick();
    valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_flush_cv", char_valid, 0);
    repeat (4) tick();

    check_eq("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
